load_store_unit: RTL

Initiator side of the core's memory access interface. Accepts one load or store request at a time from the execute stage and computes the effective address. Screens alignment and encoding locally, then drives the memory unit's op/addr/in port. Captures the memory unit's registered out/fault, sign- or zero-extends load data, and returns a one-cycle response to the pipeline.

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and memory-port bundle between the execute stage, the
// load/store unit and the memory unit.
interface load_store_unit_if #(
  parameter int OFFSET_WIDTH = 12
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_is_store;
  logic [2:0]              req_funct3;
  logic [31:0]             req_base;
  logic [OFFSET_WIDTH-1:0] req_offset;
  logic [31:0]             req_wdata;
  logic                    resp_valid;
  logic [31:0]             resp_data;
  logic                    resp_fault;
  logic [2:0]              mem_op;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;
  logic [31:0]             mem_rdata;
  logic                    mem_fault;

  // Environment side: pipeline requester plus memory responder.
  modport master (
    output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata,
    output mem_rdata, mem_fault,
    input  req_ready, resp_valid, resp_data, resp_fault,
    input  mem_op, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata,
    input  mem_rdata, mem_fault,
    output req_ready, resp_valid, resp_data, resp_fault,
    output mem_op, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator: effective address, local alignment/encoding screen,
// one-cycle memory issue and an extended, registered response.
module load_store_unit #(
  parameter int OFFSET_WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic        local_fault_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] resp_data_q;
  logic [2:0]  mem_op_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic [31:0] ea_s;
  logic        illegal_s;
  logic        misaligned_s;
  logic        local_fault_s;
  logic [31:0] resp_data_d;
  logic        resp_fault_d;

  // Effective address and local screening of the incoming request.
  always_comb begin
    ea_s = bus.req_base + {{(32-OFFSET_WIDTH){bus.req_offset[OFFSET_WIDTH-1]}}, bus.req_offset};
    if (bus.req_is_store) begin
      illegal_s = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    end else begin
      illegal_s = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
    end
    case (bus.req_funct3[1:0])
      2'b01:   misaligned_s = ea_s[0];
      2'b10:   misaligned_s = (ea_s[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
    local_fault_s = illegal_s | misaligned_s;
  end

  // Response formation from the memory unit's registered read data.
  always_comb begin
    resp_fault_d = local_fault_q | (!local_fault_q & bus.mem_fault);
    resp_data_d  = 32'd0;
    if (!is_store_q && !resp_fault_d) begin
      case (funct3_q)
        3'b000:  resp_data_d = {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
        3'b001:  resp_data_d = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
        3'b010:  resp_data_d = bus.mem_rdata;
        3'b100:  resp_data_d = {24'd0, bus.mem_rdata[7:0]};
        3'b101:  resp_data_d = {16'd0, bus.mem_rdata[15:0]};
        default: resp_data_d = 32'd0;
      endcase
    end else begin
      resp_data_d = 32'd0;
    end
  end

  // Transaction FSM; every output is a register so the memory port sees clean levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      is_store_q    <= 1'b0;
      funct3_q      <= 3'b000;
      local_fault_q <= 1'b0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_fault_q  <= 1'b0;
      resp_data_q   <= 32'd0;
      mem_op_q      <= 3'b000;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            is_store_q    <= bus.req_is_store;
            funct3_q      <= bus.req_funct3;
            local_fault_q <= local_fault_s;
            req_ready_q   <= 1'b0;
            state_q       <= ISSUE;
            // A locally faulted request never reaches memory, so stores cannot corrupt it.
            if (!local_fault_s) begin
              mem_op_q    <= {bus.req_is_store, bus.req_funct3[1:0]};
              mem_addr_q  <= ea_s;
              mem_wdata_q <= bus.req_wdata;
            end
          end
        end
        ISSUE: begin
          mem_op_q    <= 3'b000;
          mem_addr_q  <= 32'd0;
          mem_wdata_q <= 32'd0;
          state_q     <= WAIT;
        end
        WAIT: begin
          resp_data_q  <= resp_data_d;
          resp_fault_q <= resp_fault_d;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          mem_op_q     <= 3'b000;
          mem_addr_q   <= 32'd0;
          mem_wdata_q  <= 32'd0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.mem_op     = mem_op_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule
